adc_spi_responder: RTL and testbench
====================================

Name: adc_spi_responder

Overview:
- Behavioural-synthesizable responder for the LTC2308-style serial ADC link driven by the joystick ADC master (ADC_CS_N / ADC_SCLK / ADC_DIN in, ADC_DOUT out).
- Replaces the physical ADC in simulation and in loopback FPGA builds.
- Returns a 12-bit sample from an 8-channel sample bus.
- Decodes the 6-bit config word sent by the master; that config selects the channel for the next frame.
- All link inputs are oversampled on the system clock; no logic runs on ADC_SCLK.

Parameters:
- NBITS, 12, result bits shifted out per frame, MSB first.
- CFG_BITS, 6, config bits captured per frame: S/D, O/S, S1, S0, UNI, SLP.
- SYNC_STAGES, 2, synchronizer flops on each link input (minimum 2).

Ports:
- iCLK  in  1  system clock; must be at least 8x the ADC_SCLK frequency.
- Reset  in  1  asynchronous, active-low reset.
- ADC_CS_N  in  1  frame select from master; low = frame active.
- ADC_SCLK  in  1  serial clock from master.
- ADC_DIN  in  1  config bits from master, sampled on SCLK rise.
- ADC_DOUT  out  1  result bits to master, updated on SCLK fall.
- iSamples  in  8*NBITS  channel n occupies bits [n*NBITS +: NBITS].
- oConfig  out  CFG_BITS  last accepted config word.
- oConfigValid  out  1  one-cycle pulse when a config word is accepted.
- oFrameError  out  1  one-cycle pulse on a short frame.
- oBusy  out  1  high while a frame is active (synchronized CS_N low).

Behaviour:
- Reset values: ADC_DOUT=0, oConfig=6'b100000 (single-ended CH0), oConfigValid=0, oFrameError=0, oBusy=0. Bit counter, shift registers and channel register are cleared.
- Input path: CS_N, SCLK and DIN each pass through SYNC_STAGES flops.
- Edge detect: compare the last synchronized stage with a delayed copy. This gives csFall, csRise, sckRise and sckFall strobes.
- States: IDLE, SHIFT.
- IDLE -> SHIFT on csFall:
  - Capture iSamples slice for the current channel into tx_shift.
  - Drive ADC_DOUT = tx_shift[NBITS-1] on the next cycle.
  - Clear bit_cnt and rx_shift.
  - oBusy=1.
- In SHIFT, on sckRise:
  - If bit_cnt < CFG_BITS, rx_shift <= {rx_shift, DIN}.
  - bit_cnt increments, saturating at NBITS+1.
- In SHIFT, on sckFall:
  - If bit_cnt < NBITS, shift tx_shift left and drive the new MSB.
  - Otherwise drive ADC_DOUT=0.
- SHIFT -> IDLE on csRise; oBusy=0, ADC_DOUT=0.
  - If bit_cnt >= CFG_BITS: oConfig <= rx_shift, oConfigValid pulses for 1 cycle, and channel <= {rx_shift[3:2], rx_shift[4]} (S1, S0, O/S).
  - Else: config and channel are unchanged, and oFrameError pulses for 1 cycle.
- Pipelining: the config received in frame k selects the sample returned in frame k+1. The first frame after reset returns CH0.
- Latency: ADC_DOUT changes SYNC_STAGES+1 iCLK cycles after the physical SCLK fall.
- Sample capture is at csFall only; iSamples changes mid-frame do not affect the frame in progress.
- Boundaries:
  - SCLK edges while in IDLE are ignored.
  - csFall and an SCLK edge in the same cycle: the load takes priority and the SCLK edge is dropped.
  - csRise and sckRise in the same cycle: the rise is counted first, then the frame closes.
  - More than NBITS clocks in a frame: ADC_DOUT=0 and extra DIN bits are ignored.
  - Reset asserted mid-frame: immediate return to reset values. Reset release with CS_N low does not start a frame; a fresh csFall is required.
- S/D=0 (differential) words are accepted and stored in oConfig. Channel mapping is unchanged (single-ended only is modelled).

Optional Feature:
- Macro: ADC_RESP_BIPOLAR_EN.
- Defined: if the accepted config has UNI=0, the next frame's sample is output with its MSB inverted (offset binary to two's complement), e.g. 12'h800 is sent as 12'h000.
- Not defined: the UNI bit is stored in oConfig but ignored; samples are always sent straight binary.

Test Plan:
- Reset, CH0 sample=12'hABC, one 12-clock frame with DIN=6'b110000 -> DOUT shifts 101010111100; oConfig=6'b110000; oConfigValid pulses once.
- Next frame with CH1=12'h123 -> DOUT returns 12'h123 (channel from the previous config, {S1,S0,O/S}=001).
- Frame closed after 4 SCLKs -> oFrameError pulses once; oConfig and channel unchanged; the next frame returns the same channel.
- 16-clock frame, CH7=12'hFFF selected -> first 12 bits are 1, last 4 are 0; config accepted.
- Reset asserted during bit 5 -> DOUT=0 and oBusy=0 immediately. After release, the next frame returns CH0 and oConfig=6'b100000.
- With ADC_RESP_BIPOLAR_EN defined, config UNI=0, sample 12'h7FF -> next frame DOUT=12'hFFF. Without the macro -> 12'h7FF.

Source files
------------

// File: rtl/adc_spi_responder.sv
// LTC2308-style serial ADC responder: oversampled link, 6-bit config in, 12-bit sample out.
// Optional ADC_RESP_BIPOLAR_EN: UNI=0 in the accepted config sends the next sample MSB-inverted.
module adc_spi_responder #(
  parameter int NBITS       = 12,
  parameter int CFG_BITS    = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  iCLK,
  input  logic                  Reset,
  input  logic                  ADC_CS_N,
  input  logic                  ADC_SCLK,
  input  logic                  ADC_DIN,
  output logic                  ADC_DOUT,
  input  logic [8*NBITS-1:0]    iSamples,
  output logic [CFG_BITS-1:0]   oConfig,
  output logic                  oConfigValid,
  output logic                  oFrameError,
  output logic                  oBusy
);

  localparam int CW = $clog2(NBITS + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(NBITS + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                   state_q;
  logic [SYNC_STAGES-1:0]   cs_sync_q, sck_sync_q, din_sync_q;
  logic                     cs_dly_q, sck_dly_q;
  logic [NBITS-1:0]         tx_q;
  logic [CFG_BITS-1:0]      rx_q, rx_d, cfg_q;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [2:0]               chan_q;
  logic                     dout_q, cfg_vld_q, frm_err_q, busy_q;
`ifdef ADC_RESP_BIPOLAR_EN
  logic                     bip_q;
`endif

  logic cs_s, sck_s, din_s;
  logic cs_fall, cs_rise, sck_rise, sck_fall;
  logic [NBITS-1:0] sample_sel, load_word;

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign din_s    = din_sync_q[SYNC_STAGES-1];
  assign cs_fall  = cs_dly_q & ~cs_s;
  assign cs_rise  = ~cs_dly_q & cs_s;
  assign sck_rise = ~sck_dly_q & sck_s;
  assign sck_fall = sck_dly_q & ~sck_s;

  assign sample_sel = iSamples[int'(chan_q)*NBITS +: NBITS];
`ifdef ADC_RESP_BIPOLAR_EN
  assign load_word = sample_sel ^ {bip_q, {(NBITS-1){1'b0}}};
`else
  assign load_word = sample_sel;
`endif

  // Rise-updated counter/config, shared so a rise coinciding with csRise is counted before the close.
  assign cnt_d = (sck_rise && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
  assign rx_d  = (sck_rise && cnt_q < CW'(CFG_BITS)) ? {rx_q[CFG_BITS-2:0], din_s} : rx_q;

  // CS sync resets low so a release with CS_N already low never looks like a csFall.
  always_ff @(posedge iCLK or negedge Reset) begin
    if (!Reset) begin
      cs_sync_q  <= '0;
      sck_sync_q <= '0;
      din_sync_q <= '0;
      cs_dly_q   <= 1'b0;
      sck_dly_q  <= 1'b0;
    end else begin
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], ADC_CS_N};
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], ADC_SCLK};
      din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], ADC_DIN};
      cs_dly_q   <= cs_s;
      sck_dly_q  <= sck_s;
    end
  end

  always_ff @(posedge iCLK or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      cnt_q     <= '0;
      chan_q    <= '0;
      cfg_q     <= {1'b1, {(CFG_BITS-1){1'b0}}};
      dout_q    <= 1'b0;
      cfg_vld_q <= 1'b0;
      frm_err_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef ADC_RESP_BIPOLAR_EN
      bip_q     <= 1'b0;
`endif
    end else begin
      cfg_vld_q <= 1'b0;
      frm_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q <= SHIFT;
            tx_q    <= load_word;
            dout_q  <= load_word[NBITS-1];
            cnt_q   <= '0;
            rx_q    <= '0;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            dout_q  <= 1'b0;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            if (cnt_d >= CW'(CFG_BITS)) begin
              cfg_q     <= rx_d;
              cfg_vld_q <= 1'b1;
              chan_q    <= {rx_d[CFG_BITS-3], rx_d[CFG_BITS-4], rx_d[CFG_BITS-2]};
`ifdef ADC_RESP_BIPOLAR_EN
              bip_q     <= ~rx_d[CFG_BITS-5];
`endif
            end else begin
              frm_err_q <= 1'b1;
            end
          end else if (sck_rise) begin
            cnt_q <= cnt_d;
            rx_q  <= rx_d;
          end else if (sck_fall) begin
            if (cnt_q < CW'(NBITS)) begin
              tx_q   <= {tx_q[NBITS-2:0], 1'b0};
              dout_q <= tx_q[NBITS-2];
            end else begin
              dout_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ADC_DOUT     = dout_q;
  assign oConfig      = cfg_q;
  assign oConfigValid = cfg_vld_q;
  assign oFrameError  = frm_err_q;
  assign oBusy        = busy_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: table of frames plus hand-written reset/edge-coincidence sequences.
module tb_adc_spi_responder;

  logic        iCLK, Reset, ADC_CS_N, ADC_SCLK, ADC_DIN, ADC_DOUT;
  logic [95:0] samples;
  logic [5:0]  oConfig;
  logic        oConfigValid, oFrameError, oBusy;

  int compared = 0, mismatched = 0;
  int vld_cnt = 0, err_cnt = 0;
  logic [15:0] exp_q[$];

`ifdef ADC_RESP_BIPOLAR_EN
  localparam logic BIP = 1'b1;
`else
  localparam logic BIP = 1'b0;
`endif

  adc_spi_responder dut (
    .iCLK(iCLK), .Reset(Reset), .ADC_CS_N(ADC_CS_N), .ADC_SCLK(ADC_SCLK),
    .ADC_DIN(ADC_DIN), .ADC_DOUT(ADC_DOUT), .iSamples(samples),
    .oConfig(oConfig), .oConfigValid(oConfigValid), .oFrameError(oFrameError), .oBusy(oBusy)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  always @(negedge iCLK) begin
    if (oConfigValid) vld_cnt++;
    if (oFrameError)  err_cnt++;
  end

  typedef struct {
    int          n;
    logic [5:0]  cfg;
    logic [15:0] exp_cap;
    logic [5:0]  exp_cfg;
    int          exp_vld;
    int          exp_err;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_sample(input int ch, input logic [11:0] v);
    samples[ch*12 +: 12] = v;
  endtask

  // Master model: SCLK period 8 iCLK, DIN changes on fall, DOUT sampled just before each rise.
  task automatic run_frame(input int n, input logic [5:0] cfg, input bit cs_on_last,
                           output logic [15:0] cap);
    cap = '0;
    vld_cnt = 0;
    err_cnt = 0;
    ADC_CS_N = 1'b0;
    #80;
    chk("busy_in_frame", {31'b0, oBusy}, 32'd1);
    for (int i = 0; i < n; i++) begin
      ADC_DIN = (i < 6) ? cfg[5-i] : 1'b1;
      #40;
      cap = {cap[14:0], ADC_DOUT};
      ADC_SCLK = 1'b1;
      if (cs_on_last && i == n-1) ADC_CS_N = 1'b1;
      #40;
      ADC_SCLK = 1'b0;
    end
    #80;
    ADC_CS_N = 1'b1;
    #120;
  endtask

  task automatic frame_check(input string tag, input int n, input logic [5:0] cfg,
                             input bit cs_on_last, input logic [15:0] exp_cap,
                             input logic [5:0] exp_cfg, input int exp_vld, input int exp_err);
    logic [15:0] cap;
    exp_q.push_back(exp_cap);
    run_frame(n, cfg, cs_on_last, cap);
    chk({tag, "_dout"}, {16'b0, cap}, {16'b0, exp_q.pop_front()});
    chk({tag, "_cfg"}, {26'b0, oConfig}, {26'b0, exp_cfg});
    chk({tag, "_vld"}, vld_cnt, exp_vld);
    chk({tag, "_err"}, err_cnt, exp_err);
  endtask

  initial begin
    Reset = 1'b0; ADC_CS_N = 1'b1; ADC_SCLK = 1'b0; ADC_DIN = 1'b0;
    set_sample(0, 12'hABC); set_sample(1, 12'h123); set_sample(2, 12'h456);
    set_sample(3, 12'h789); set_sample(4, 12'h7FF); set_sample(5, 12'h800);
    set_sample(6, 12'h0F0); set_sample(7, 12'hFFF);

    tbl[0] = '{12, 6'b110000, 16'hABC,                 6'b110000, 1, 0};
    tbl[1] = '{12, 6'b101110, 16'h123 ^ {4'b0, BIP, 11'b0}, 6'b101110, 1, 0};
    tbl[2] = '{4,  6'b111100, 16'h0,                   6'b101110, 0, 1};
    tbl[3] = '{12, 6'b111110, 16'h0F0,                 6'b111110, 1, 0};
    tbl[4] = '{16, 6'b100010, 16'hFFF0,                6'b100010, 1, 0};
    tbl[5] = '{6,  6'b010110, 16'h2A,                  6'b010110, 1, 0};
    tbl[6] = '{5,  6'b111111, 16'h0F,                  6'b010110, 0, 1};
    tbl[7] = '{12, 6'b101010, 16'h789,                 6'b101010, 1, 0};
    tbl[8] = '{12, 6'b110010, 16'h7FF,                 6'b110010, 1, 0};

    @(negedge iCLK);
    #10;
    chk("rst_dout",  {31'b0, ADC_DOUT}, 32'd0);
    chk("rst_cfg",   {26'b0, oConfig}, 32'h20);
    chk("rst_vld",   {31'b0, oConfigValid}, 32'd0);
    chk("rst_err",   {31'b0, oFrameError}, 32'd0);
    chk("rst_busy",  {31'b0, oBusy}, 32'd0);
    Reset = 1'b1;
    #40;

    for (int k = 0; k < 9; k++)
      frame_check($sformatf("tbl%0d", k), tbl[k].n, tbl[k].cfg, 1'b0, tbl[k].exp_cap,
                  tbl[k].exp_cfg, tbl[k].exp_vld, tbl[k].exp_err);

    // SCLK activity with CS_N high must not disturb anything.
    for (int i = 0; i < 3; i++) begin
      ADC_SCLK = 1'b1; #40; ADC_SCLK = 1'b0; #40;
    end
    chk("idle_sclk_busy", {31'b0, oBusy}, 32'd0);

    // UNI=0 selecting CH4: the following frame is MSB-inverted only with the bipolar option.
    frame_check("bip_cfg", 12, 6'b101000, 1'b0, 16'h123, 6'b101000, 1, 0);
    frame_check("bip_out", 12, 6'b110010, 1'b0, 16'h7FF ^ {4'b0, BIP, 11'b0}, 6'b110010, 1, 0);

    // iSamples change mid-frame must not affect the word already loaded.
    fork
      frame_check("midchg", 12, 6'b110010, 1'b0, 16'h123, 6'b110010, 1, 0);
      begin #400; set_sample(1, 12'h000); end
    join
    set_sample(1, 12'h123);

    // Sixth rise coincides with CS_N rise: counted first, so the config is accepted.
    frame_check("csrise_sck", 6, 6'b111110, 1'b1, 16'h04, 6'b111110, 1, 0);
    frame_check("after_cs6", 12, 6'b111110, 1'b0, 16'hFFF, 6'b111110, 1, 0);

    // Reset during the frame: CH7 selected, DOUT is 1 before reset.
    ADC_CS_N = 1'b0;
    #80;
    for (int i = 0; i < 4; i++) begin
      ADC_DIN = 1'b0; #40; ADC_SCLK = 1'b1; #40; ADC_SCLK = 1'b0;
    end
    #40;
    chk("pre_rst_dout", {31'b0, ADC_DOUT}, 32'd1);
    Reset = 1'b0;
    #1;
    chk("midrst_dout", {31'b0, ADC_DOUT}, 32'd0);
    chk("midrst_busy", {31'b0, oBusy}, 32'd0);
    chk("midrst_cfg",  {26'b0, oConfig}, 32'h20);
    #29;
    Reset = 1'b1;
    #100;
    chk("rel_cs_low_busy", {31'b0, oBusy}, 32'd0);
    ADC_CS_N = 1'b1;
    #80;
    frame_check("post_rst", 12, 6'b110000, 1'b0, 16'hABC, 6'b110000, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
